// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared FSM encodings, read-latency constant and default
//               widths for the framebuffer access arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    // 160x120 framebuffer words, RRRGGGBB pixels
    localparam int C_ADDR_W   = 15;
    localparam int C_DATA_W   = 8;

    // Display request sample to pixel valid, in clock cycles
    localparam int C_RD_LAT   = 3;

    // Width of the optional writer-starvation counter
    localparam int C_STARVE_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DISP = 2'd1,
        S_WR   = 2'd2
    } fb_state_e;

endpackage : fb_pkg
`default_nettype wire

// File: rtl/fb_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fb_rd_pipe
// Description : Read-return delay line. Tracks which cycles carry a display
//               fetch and captures the RAM read data into the pixel output,
//               forcing the pixel to zero on cycles without a valid fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_rd_pipe
    import fb_pkg::*;
#(
    parameter int P_DATA_W = C_DATA_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_i,   // RAM address phase of a fetch this cycle
    input  logic [P_DATA_W-1:0] rdata_i,   // RAM read data, one cycle after address
    output logic                valid_o,
    output logic [P_DATA_W-1:0] data_o
);

    // The arbiter's state register supplies the first cycle of latency, so the
    // shift register covers the remainder. Data is captured one stage before
    // the end, when the single-cycle RAM presents the read word.
    localparam int C_STAGES = C_RD_LAT - 1;

    logic [C_STAGES-1:0] valid_q;
    logic [P_DATA_W-1:0] data_q;

    // Shift fetch markers and capture RAM data; reset drops all in-flight reads
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= {valid_q[C_STAGES-2:0], issue_i};
            data_q  <= valid_q[C_STAGES-2] ? rdata_i : '0;
        end
    end

    assign valid_o = valid_q[C_STAGES-1];
    assign data_o  = data_q;

endmodule : fb_rd_pipe
`default_nettype wire

// File: rtl/fb_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_access_arbiter
// Description : Arbitrates a single-port framebuffer RAM between a display
//               fetch port (absolute priority, one pixel per clock) and a
//               writer port (request held until granted, never granted on two
//               consecutive cycles). All outputs are registered.
//               Optional macro FB_ACCESS_ARBITER_STARVE_CNT_EN adds a
//               saturating count of cycles the writer waited ungranted.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_access_arbiter
    import fb_pkg::*;
#(
    parameter int P_ADDR_W = C_ADDR_W,
    parameter int P_DATA_W = C_DATA_W
) (
    input  logic                i_CLK,
    input  logic                i_RESET,
    input  logic                i_DISP_REQ,
    input  logic [P_ADDR_W-1:0] i_DISP_ADDR,
    output logic [P_DATA_W-1:0] o_DISP_DATA,
    output logic                o_DISP_VALID,
    input  logic                i_WR_REQ,
    input  logic [P_ADDR_W-1:0] i_WR_ADDR,
    input  logic [P_DATA_W-1:0] i_WR_DATA,
    output logic                o_WR_GNT,
    output logic [P_ADDR_W-1:0] o_MEM_ADDR,
    output logic                o_MEM_WE,
    output logic [P_DATA_W-1:0] o_MEM_WDATA,
    input  logic [P_DATA_W-1:0] i_MEM_RDATA
`ifdef FB_ACCESS_ARBITER_STARVE_CNT_EN
    ,
    output logic [C_STARVE_W-1:0] o_STARVE_CNT
`endif
);

    fb_state_e           state_q, state_d;
    logic [P_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [P_DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                wr_gnt_q, wr_gnt_d;

    // Next-state: display always wins; writer only when not granted last cycle
    always_comb begin
        state_d     = S_IDLE;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        wr_gnt_d    = 1'b0;
        if (i_DISP_REQ) begin
            state_d    = S_DISP;
            mem_addr_d = i_DISP_ADDR;
        end else if (i_WR_REQ && (state_q != S_WR)) begin
            state_d     = S_WR;
            mem_addr_d  = i_WR_ADDR;
            mem_wdata_d = i_WR_DATA;
            mem_we_d    = 1'b1;
            wr_gnt_d    = 1'b1;
        end
    end

    // State and registered RAM/grant outputs
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            wr_gnt_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            wr_gnt_q    <= wr_gnt_d;
        end
    end

    assign o_MEM_ADDR  = mem_addr_q;
    assign o_MEM_WDATA = mem_wdata_q;
    assign o_MEM_WE    = mem_we_q;
    assign o_WR_GNT    = wr_gnt_q;

    fb_rd_pipe #(
        .P_DATA_W (P_DATA_W)
    ) u_rd_pipe (
        .clk_i   (i_CLK),
        .rst_i   (i_RESET),
        .issue_i (state_q == S_DISP),
        .rdata_i (i_MEM_RDATA),
        .valid_o (o_DISP_VALID),
        .data_o  (o_DISP_DATA)
    );

`ifdef FB_ACCESS_ARBITER_STARVE_CNT_EN
    logic [C_STARVE_W-1:0] starve_q;

    // Count waiting cycles of the writer; cleared on each grant, saturating
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            starve_q <= '0;
        end else if (wr_gnt_q) begin
            starve_q <= '0;
        end else if (i_WR_REQ && (starve_q != {C_STARVE_W{1'b1}})) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    assign o_STARVE_CNT = starve_q;
`endif

endmodule : fb_access_arbiter
`default_nettype wire

// File: doc/fb_access_arbiter.md
FB_ACCESS_ARBITER -- requirements
Module: fb_access_arbiter

Interface
REQ-001 SHALL have parameter P_ADDR_W, default 15, meaning framebuffer word-address width (160x120 = 19200 words).
REQ-002 SHALL have parameter P_DATA_W, default 8, meaning pixel width in RRRGGGBB format.
REQ-003 SHALL have port i_CLK  input  1  single clock for all logic.
REQ-004 SHALL have port i_RESET  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports i_DISP_REQ  input  1  display fetch request; i_DISP_ADDR  input  P_ADDR_W  fetch address.
REQ-006 SHALL have ports o_DISP_DATA  output  P_DATA_W  fetched pixel; o_DISP_VALID  output  1  fetched pixel valid.
REQ-007 SHALL have ports i_WR_REQ  input  1  writer request, held until granted; i_WR_ADDR  input  P_ADDR_W; i_WR_DATA  input  P_DATA_W.
REQ-008 SHALL have port o_WR_GNT  output  1  one-cycle pulse: write committed this cycle.
REQ-009 SHALL have ports o_MEM_ADDR  output  P_ADDR_W; o_MEM_WE  output  1; o_MEM_WDATA  output  P_DATA_W; i_MEM_RDATA  input  P_DATA_W (single-port RAM, 1-cycle registered read).

Function
REQ-010 SHALL implement FSM states S_IDLE, S_DISP, S_WR; all outputs registered.
REQ-011 SHALL grant the display strictly first: any cycle with i_DISP_REQ=1 enters S_DISP next cycle, regardless of i_WR_REQ.
REQ-012 SHALL enter S_WR only when i_DISP_REQ=0, i_WR_REQ=1 and the current state is not S_WR.
REQ-013 SHALL, in S_DISP, drive o_MEM_ADDR=registered i_DISP_ADDR, o_MEM_WE=0.
REQ-014 SHALL, in S_WR, drive o_MEM_ADDR/o_MEM_WDATA=registered i_WR_ADDR/i_WR_DATA, o_MEM_WE=1, o_WR_GNT=1.
REQ-015 SHALL deliver o_DISP_DATA with o_DISP_VALID=1 exactly 3 cycles after the i_DISP_REQ sample (N -> N+3), one valid pulse per request.
REQ-016 SHALL accept display requests on consecutive cycles, sustaining one pixel per clock.
REQ-017 SHALL never grant the writer on two consecutive cycles; a held i_WR_REQ after a grant is re-granted at the earliest 2 cycles later.
REQ-018 SHALL, in S_IDLE, drive o_MEM_WE=0, o_WR_GNT=0, o_MEM_ADDR held at its last value.
REQ-019 SHALL let a pending writer wait indefinitely under continuous display requests (no pre-emption of display).
REQ-020 SHALL return o_DISP_DATA=0 whenever o_DISP_VALID=0.

Reset
REQ-021 SHALL, while i_RESET=1 at a clock edge, set state S_IDLE and o_DISP_VALID, o_DISP_DATA, o_WR_GNT, o_MEM_WE, o_MEM_ADDR, o_MEM_WDATA all to 0.
REQ-022 SHALL discard in-flight reads on reset: no o_DISP_VALID pulse for requests sampled before or during reset.
REQ-023 SHALL ignore i_DISP_REQ and i_WR_REQ in the cycle i_RESET=1; first grant possible on the cycle after reset deasserts.

Configuration
REQ-024 SHALL support macro FB_ACCESS_ARBITER_STARVE_CNT_EN.
REQ-025 SHALL, with the macro defined, add output o_STARVE_CNT  16 bits: count of cycles with i_WR_REQ=1 and no grant, saturating at 16'hFFFF, cleared by reset and on each o_WR_GNT.
REQ-026 SHALL, without the macro, omit o_STARVE_CNT and its logic entirely; all other behaviour identical.

Structure
REQ-027 SHALL place state encodings (S_IDLE, S_DISP, S_WR), the 3-cycle read latency constant and default widths in shared package fb_pkg.
REQ-028 SHALL implement the read valid/data delay line as sub-module fb_rd_pipe (valid shift register plus data capture).

Verification
REQ-029 SHALL cover: i_DISP_REQ=1, i_DISP_ADDR=0x0010, RAM[0x10]=0xE3 at cycle 5 -> o_DISP_VALID=1, o_DISP_DATA=0xE3 at cycle 8.
REQ-030 SHALL cover: i_DISP_REQ and i_WR_REQ both 1 at cycle 5 (WR addr 0x20, data 0x1C) -> S_DISP at 6, o_WR_GNT=1 and o_MEM_WE=1 with o_MEM_ADDR=0x20 at 7.
REQ-031 SHALL cover: i_WR_REQ held high 6 cycles, no display -> o_WR_GNT pulses on alternate cycles only (3 grants).
REQ-032 SHALL cover: 640 consecutive display requests, addresses 0..639 -> 640 valid pulses, in order, no gaps, o_MEM_WE=0 throughout.
REQ-033 SHALL cover: i_RESET=1 one cycle after a display request -> no o_DISP_VALID pulse, all outputs 0 next cycle.
REQ-034 SHALL cover (macro defined): writer held 100 cycles behind continuous display -> o_STARVE_CNT=100, returns to 0 on grant.
